// File: rtl/am_mem_server.sv
// am_mem_server: scratchpad read/write/echo server behind FIFO-buffered request and response queues.
// One request executes at a time; READ spends an extra cycle waiting on the synchronous memory.
module am_mem_server #(
    parameter int SDARG_BITS = 32,
    parameter int DATA_BITS  = 512,
    parameter int MEM_WORDS  = 256,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx,
    input  logic [6*SDARG_BITS-1:0] tx_head,
    input  logic [DATA_BITS-1:0]    tx_data,
    output logic                    tx_full,
    output logic                    rx_empty,
    output logic [6*SDARG_BITS-1:0] rx_head,
    output logic [DATA_BITS-1:0]    rx_data,
    input  logic                    rx_pop,
    output logic [15:0]             drop_cnt
);
    localparam int HW = 6 * SDARG_BITS;
    localparam int EW = HW + DATA_BITS;
    localparam int QA = $clog2(REQ_DEPTH);
    localparam int SA = $clog2(RSP_DEPTH);
    localparam int MA = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         req_mem [REQ_DEPTH];
    logic [EW-1:0]         rsp_mem [RSP_DEPTH];
    logic [DATA_BITS-1:0]  mem [MEM_WORDS];
    logic [QA-1:0]         req_wp_q, req_wp_d, req_rp_q, req_rp_d;
    logic [QA:0]           req_cnt_q, req_cnt_d;
    logic [SA-1:0]         rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [SA:0]           rsp_cnt_q, rsp_cnt_d;
    logic [15:0]           drop_q, drop_d;
    logic [HW-1:0]         pend_head_q, pend_head_d;
    logic [DATA_BITS-1:0]  rd_data_q;
    logic                  req_push, req_pop, rsp_push, rsp_pop, mem_we, mem_re, addr_ok;
    logic [EW-1:0]         req_ent, rsp_ent;
    logic [SDARG_BITS-1:0] srcid, dstid, arg0, arg1, arg2;
    logic [1:0]            op, status;
    logic [HW-1:0]         rsp_head;
    logic [DATA_BITS-1:0]  req_data;

    assign tx_full  = req_cnt_q == (QA+1)'(REQ_DEPTH);
    assign rx_empty = rsp_cnt_q == '0;
    assign {rx_head, rx_data} = rx_empty ? '0 : rsp_mem[rsp_rp_q];
    assign drop_cnt = drop_q;
    assign req_push = tx && !tx_full;
    assign rsp_pop  = rx_pop && !rx_empty;

    // Decode of the oldest request; its arg3 is overwritten by the status in the reply.
    assign req_ent  = req_mem[req_rp_q];
    assign {srcid, dstid, arg0, arg1, arg2} = req_ent[EW-1 -: 5*SDARG_BITS];
    assign req_data = req_ent[DATA_BITS-1:0];
    assign op       = arg0[1:0];
    assign addr_ok  = arg1 < SDARG_BITS'(MEM_WORDS);
    assign status   = (op == 2'd3) ? 2'd2 : (op != 2'd2 && !addr_ok) ? 2'd1 : 2'd0;
    assign rsp_head = {dstid, srcid, arg0, arg1, arg2, SDARG_BITS'(status)};

    always_comb begin
        state_d     = state_q;
        req_pop     = 1'b0;
        rsp_push    = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        pend_head_d = pend_head_q;
        rsp_ent     = '0;
        if (state_q == RD_WAIT) begin
            rsp_push = 1'b1;
            rsp_ent  = {pend_head_q, rd_data_q};
            state_d  = IDLE;
        end else if (req_cnt_q != '0 && rsp_cnt_q < (SA+1)'(RSP_DEPTH)) begin
            req_pop = 1'b1;
            if (op == 2'd0 && addr_ok) begin
                mem_re      = 1'b1;
                pend_head_d = rsp_head;
                state_d     = RD_WAIT;
            end else begin
                rsp_push = 1'b1;
                rsp_ent  = {rsp_head, req_data & {DATA_BITS{status == 2'd0}}};
                mem_we   = (op == 2'd1) && (status == 2'd0);
            end
        end
    end

    always_comb begin
        req_wp_d  = req_wp_q + QA'(req_push);
        req_rp_d  = req_rp_q + QA'(req_pop);
        req_cnt_d = req_cnt_q + (QA+1)'(req_push) - (QA+1)'(req_pop);
        rsp_wp_d  = rsp_wp_q + SA'(rsp_push);
        rsp_rp_d  = rsp_rp_q + SA'(rsp_pop);
        rsp_cnt_d = rsp_cnt_q + (SA+1)'(rsp_push) - (SA+1)'(rsp_pop);
        drop_d    = (tx && tx_full && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_wp_q    <= '0;
            req_rp_q    <= '0;
            req_cnt_q   <= '0;
            rsp_wp_q    <= '0;
            rsp_rp_q    <= '0;
            rsp_cnt_q   <= '0;
            drop_q      <= '0;
            pend_head_q <= '0;
        end else begin
            state_q     <= state_d;
            req_wp_q    <= req_wp_d;
            req_rp_q    <= req_rp_d;
            req_cnt_q   <= req_cnt_d;
            rsp_wp_q    <= rsp_wp_d;
            rsp_rp_q    <= rsp_rp_d;
            rsp_cnt_q   <= rsp_cnt_d;
            drop_q      <= drop_d;
            pend_head_q <= pend_head_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters decide what is valid.
    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wp_q] <= {tx_head, tx_data};
        if (rsp_push) rsp_mem[rsp_wp_q] <= rsp_ent;
        if (mem_we) mem[arg1[MA-1:0]] <= req_data;
        if (mem_re) rd_data_q <= mem[arg1[MA-1:0]];
    end
endmodule

// File: tb/tb_am_mem_server.sv
// tb_am_mem_server: scoreboard bench; requests push modelled replies, a monitor checks every popped reply.
module tb_am_mem_server;
    localparam int SD = 32;
    localparam int DW = 512;
    localparam int MW = 256;
    localparam int HW = 6 * SD;

    typedef logic [HW+DW-1:0] rsp_t;

    logic          clk = 1'b0, rst_n = 1'b0, tx = 1'b0, rx_pop = 1'b0;
    logic [HW-1:0] tx_head = '0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_full, rx_empty;
    logic [HW-1:0] rx_head;
    logic [DW-1:0] rx_data;
    logic [15:0]   drop_cnt;

    rsp_t          sb[$];
    logic [DW-1:0] model[int];
    int            n_checks = 0;
    int            n_fail = 0;

    am_mem_server dut (
        .clk(clk), .rst_n(rst_n), .tx(tx), .tx_head(tx_head), .tx_data(tx_data),
        .tx_full(tx_full), .rx_empty(rx_empty), .rx_head(rx_head), .rx_data(rx_data),
        .rx_pop(rx_pop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input rsp_t act, input rsp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference server: status from the opcode/address rules, memory as a sparse array.
    function automatic rsp_t model_rsp(input logic [31:0] s, d, a0, a1, a2, input logic [DW-1:0] data);
        int            st;
        logic [DW-1:0] r;
        st = (a0[1:0] == 2'd3) ? 2 : (a0[1:0] != 2'd2 && a1 >= MW) ? 1 : 0;
        r  = '0;
        if (st == 0) begin
            if (a0[1:0] == 2'd0) r = model.exists(int'(a1)) ? model[int'(a1)] : 'x;
            else begin
                r = data;
                if (a0[1:0] == 2'd1) model[int'(a1)] = data;
            end
        end
        return {d, s, a0, a1, a2, 32'(st), r};
    endfunction

    task automatic send(input logic [31:0] s, d, a0, a1, a2, input logic [DW-1:0] data, input bit acc);
        tx_head = {s, d, a0, a1, a2, 32'($urandom())};
        tx_data = data;
        tx = 1'b1;
        if (acc) sb.push_back(model_rsp(s, d, a0, a1, a2, data));
        @(posedge clk);
        #1 tx = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        rx_pop = 1'b1;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1 chk("drain_left", rsp_t'(sb.size()), '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && !rx_empty && rx_pop) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got %h expected none", {rx_head, rx_data});
            end else chk("rsp", {rx_head, rx_data}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a1;
        int          op;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_empty", rsp_t'(rx_empty), rsp_t'(1));
        chk("rst_tx_full", rsp_t'(tx_full), '0);
        chk("rst_drop", rsp_t'(drop_cnt), '0);
        chk("rst_rx_head", rsp_t'(rx_head), '0);
        chk("rst_rx_data", rsp_t'(rx_data), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WRITE then READ of word 5 with latency checks
        send(32'h11, 32'h22, 1, 5, 0, {64{8'hA5}}, 1);
        @(posedge clk);
        #1 chk("wr_latency", rsp_t'(rx_empty), '0);
        rx_pop = 1'b1;
        @(posedge clk);
        #1 rx_pop = 1'b0;
        send(32'h33, 32'h44, 0, 5, 1, rnd(), 1);
        @(posedge clk);
        #1 chk("rd_latency_c1", rsp_t'(rx_empty), rsp_t'(1));
        @(posedge clk);
        #1 chk("rd_latency_c2", rsp_t'(rx_empty), '0);
        wait_drain();

        // Error statuses leave memory untouched
        send(1, 2, 1, 0, 10, rnd(), 1);
        send(1, 2, 1, MW, 11, rnd(), 1);
        send(1, 2, 3, 0, 12, rnd(), 1);
        send(1, 2, 0, MW, 13, rnd(), 1);
        send(1, 2, 32'hFFFF_FFF7, 0, 14, rnd(), 1);
        send(1, 2, 0, 0, 15, rnd(), 1);
        wait_drain();

        // Back-pressure: 4 replies + 4 requests buffered, 2 strobes dropped
        rx_pop = 1'b0;
        for (int i = 0; i < 10; i++) send(7, 9, 2, 3, i, rnd(), i < 8);
        chk("bp_tx_full", rsp_t'(tx_full), rsp_t'(1));
        chk("bp_drop", rsp_t'(drop_cnt), rsp_t'(2));
        wait_drain();

        // Pop while empty is ignored
        repeat (3) @(posedge clk);
        #1 chk("empty_pop_flag", rsp_t'(rx_empty), rsp_t'(1));
        chk("empty_pop_head", rsp_t'(rx_head), '0);
        send(5, 6, 2, 0, 20, rnd(), 1);
        wait_drain();

        // Asynchronous reset while a READ waits on memory
        rx_pop = 1'b0;
        send(5, 6, 0, 5, 21, rnd(), 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rx_empty", rsp_t'(rx_empty), rsp_t'(1));
        chk("arst_tx_full", rsp_t'(tx_full), '0);
        chk("arst_drop", rsp_t'(drop_cnt), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("arst_no_stale", rsp_t'(rx_empty), rsp_t'(1));

        // Full reply FIFO, single pop with a request pending
        for (int i = 0; i < 5; i++) send(3, 4, 2, 1, 100 + i, rnd(), 1);
        repeat (4) @(posedge clk);
        #1 chk("full_rsp", rsp_t'(rx_empty), '0);
        rx_pop = 1'b1;
        @(posedge clk);
        #1 rx_pop = 1'b0;
        @(posedge clk);
        #1 chk("full_refill", rsp_t'(rx_empty), '0);
        wait_drain();

        // Randomized traffic, one request every other cycle
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            a1 = ($urandom_range(0, 9) == 0) ? MW + $urandom_range(0, 3) : $urandom_range(0, 7);
            if (op == 0 && a1 < MW && !model.exists(int'(a1))) op = 1;
            a0 = ($urandom() & 32'hFFFF_FFFC) | 32'(op);
            chk("rand_tx_full", rsp_t'(tx_full), '0);
            send($urandom(), $urandom(), a0, a1, n, rnd(), 1);
            @(posedge clk);
            #1;
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
